bcd_operand_alu: RTL and testbench

- Parametrised successor to the fixed 3-digit BCD operand registers in the calculator datapath.
- Holds two DIGITS-wide BCD operands A and B, with digit entry, backspace and clear on each, plus a memory register (MS/MR/MC).
- Executes digit-serial BCD add and subtract, one digit per clock, LSD first; the result is written back into A.
- Sits between the control FSM strobes and the display mux.

---
 rtl/bcd_operand_alu.sv | 229 ++++++++++++++++++++++
 tb/tb_bcd_operand_alu.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_operand_alu.sv
// bcd_operand_alu: two DIGITS-wide BCD operand registers (A, B) with digit
// entry, backspace and clear, a memory register (MS/MR/MC), and a
// digit-serial BCD add/subtract engine that writes its result back into A.
// A negative subtraction result is left as a magnitude in A, with the
// negative flag set.
module bcd_operand_alu #(
  parameter int DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            digit,
  input  logic                  load_A,
  input  logic                  load_B,
  input  logic                  bksp_A,
  input  logic                  bksp_B,
  input  logic                  clear_A,
  input  logic                  clear_B,
  input  logic [1:0]            op_code,
  input  logic                  ex_start,
  input  logic                  ms_in,
  input  logic                  mr_in,
  input  logic                  mc_in,
  output logic [4*DIGITS-1:0]   bcd_A,
  output logic [4*DIGITS-1:0]   bcd_B,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  negative,
  output logic                  mem_valid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, COMP, DONE} state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic            c_q;
  logic            sub_q;
  logic [W-1:0]    a_q, b_q, m_q;
  logic            busy_q, done_q, ovf_q, neg_q, mv_q;

  // Digit-serial datapath signals
  logic [3:0]      a_dig, b_dig;
  logic [4:0]      add_t, add_m10, sub_t, sub_m10, cmp_t;
  logic [3:0]      step_dig;
  logic            step_c;
  logic [W-1:0]    a_step;
  logic            last_dig;

  // Idle-time entry / memory next-state
  logic [W-1:0]    a_d, b_d, m_d;
  logic            mv_d;
  logic            a_mod;
  logic            ex_ok;

  assign ex_ok    = ex_start && !op_code[1];
  assign last_dig = (idx_q == IW'(DIGITS - 1));

  // One BCD digit step: add, subtract, or ten's complement (0 - a - borrow)
  always_comb begin
    a_dig    = a_q[4*int'(idx_q) +: 4];
    b_dig    = b_q[4*int'(idx_q) +: 4];
    add_t    = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, c_q};
    add_m10  = add_t - 5'd10;
    // Biased by +10 so the intermediate never goes negative in 5 bits
    sub_t    = {1'b0, a_dig} + 5'd10 - {1'b0, b_dig} - {4'd0, c_q};
    sub_m10  = sub_t - 5'd10;
    cmp_t    = 5'd10 - {1'b0, a_dig} - {4'd0, c_q};
    step_dig = 4'd0;
    step_c   = 1'b0;
    if (state_q == COMP) begin
      // cmp_t == 10 only when a_dig == 0 and no borrow in
      if (cmp_t == 5'd10) begin
        step_dig = 4'd0;
        step_c   = 1'b0;
      end else begin
        step_dig = cmp_t[3:0];
        step_c   = 1'b1;
      end
    end else if (sub_q) begin
      if (sub_t >= 5'd10) begin
        step_dig = sub_m10[3:0];
        step_c   = 1'b0;
      end else begin
        step_dig = sub_t[3:0];
        step_c   = 1'b1;
      end
    end else begin
      if (add_t > 5'd9) begin
        step_dig = add_m10[3:0];
        step_c   = 1'b1;
      end else begin
        step_dig = add_t[3:0];
        step_c   = 1'b0;
      end
    end
  end

  // A with the current digit replaced by the step result
  always_comb begin
    a_step = a_q;
    a_step[4*int'(idx_q) +: 4] = step_dig;
  end

  // Idle entry actions: memory ops and A edits share one priority chain,
  // B has its own chain; ignored strobes fall through to the next one
  always_comb begin
    a_d   = a_q;
    m_d   = m_q;
    mv_d  = mv_q;
    a_mod = 1'b0;
    if (mc_in) begin
      m_d  = '0;
      mv_d = 1'b0;
    end else if (ms_in) begin
      m_d  = a_q;
      mv_d = 1'b1;
    end else if (mr_in && mv_q) begin
      a_d   = m_q;
      a_mod = 1'b1;
    end else if (clear_A) begin
      a_d   = '0;
      a_mod = 1'b1;
    end else if (bksp_A) begin
      a_d   = a_q >> 4;
      a_mod = 1'b1;
    end else if (load_A && (digit <= 4'd9)) begin
      a_d   = (a_q << 4) | W'(digit);
      a_mod = 1'b1;
    end

    b_d = b_q;
    if (clear_B)
      b_d = '0;
    else if (bksp_B)
      b_d = b_q >> 4;
    else if (load_B && (digit <= 4'd9))
      b_d = (b_q << 4) | W'(digit);
  end

  // Control FSM with registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      mv_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ex_ok) begin
            sub_q   <= op_code[0];
            idx_q   <= '0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            m_q  <= m_d;
            mv_q <= mv_d;
            if (a_mod) begin
              ovf_q <= 1'b0;
              neg_q <= 1'b0;
            end
          end
        end
        CALC: begin
          a_q <= a_step;
          c_q <= step_c;
          if (last_dig) begin
            idx_q <= '0;
            if (!sub_q) begin
              ovf_q   <= step_c;
              state_q <= DONE;
            end else if (step_c) begin
              // Final borrow: A holds 10^DIGITS + a - b, complement it
              neg_q   <= 1'b1;
              c_q     <= 1'b0;
              state_q <= COMP;
            end else begin
              state_q <= DONE;
            end
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        COMP: begin
          a_q <= a_step;
          c_q <= step_c;
          if (last_dig) begin
            idx_q   <= '0;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd_A     = a_q;
  assign bcd_B     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign negative  = neg_q;
  assign mem_valid = mv_q;

endmodule

// File: tb/tb_bcd_operand_alu.sv
// Scoreboard bench for bcd_operand_alu: the driver updates a decimal-value
// model at every clock edge and queues the expected outputs; a monitor
// pops and compares them on the following falling edge.
module tb_bcd_operand_alu;

  localparam int D = 3;
  localparam int W = 4 * D;
  localparam int P = 1000; // 10**D

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   digit = '0;
  logic         load_A = 0, load_B = 0, bksp_A = 0, bksp_B = 0;
  logic         clear_A = 0, clear_B = 0, ex_start = 0;
  logic         ms_in = 0, mr_in = 0, mc_in = 0;
  logic [1:0]   op_code = '0;
  logic [W-1:0] bcd_A, bcd_B;
  logic         busy, done, overflow, negative, mem_valid;

  bcd_operand_alu #(.DIGITS(D)) dut (
    .clock(clock), .reset(reset), .digit(digit),
    .load_A(load_A), .load_B(load_B), .bksp_A(bksp_A), .bksp_B(bksp_B),
    .clear_A(clear_A), .clear_B(clear_B), .op_code(op_code),
    .ex_start(ex_start), .ms_in(ms_in), .mr_in(mr_in), .mc_in(mc_in),
    .bcd_A(bcd_A), .bcd_B(bcd_B), .busy(busy), .done(done),
    .overflow(overflow), .negative(negative), .mem_valid(mem_valid)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [W-1:0] a, b;
    logic       ovf, neg, mv, busy, done;
    bit         chk_a;
    string      nm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Model state in plain decimal
  int ma = 0, mb = 0, mm = 0;
  bit mmv = 0, movf = 0, mneg = 0;
  int bl = 0;            // edges remaining until done
  int pres = 0;
  bit povf = 0, pneg = 0;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // One clock edge: model absorbs the inputs sampled there, expectation queued
  task automatic tick(input string nm);
    exp_t e;
    bit eb, ed;
    @(posedge clock);
    #1;
    eb = 0;
    ed = 0;
    if (reset) begin
      ma = 0; mb = 0; mm = 0; mmv = 0; movf = 0; mneg = 0; bl = 0;
    end else if (bl > 0) begin
      bl--;
      if (bl == 0) begin
        ma = pres; movf = povf; mneg = pneg; ed = 1;
      end else begin
        eb = 1;
      end
    end else if (ex_start && op_code < 2) begin
      if (op_code == 0) begin
        povf = (ma + mb) >= P;
        pneg = 0;
        pres = (ma + mb) % P;
        bl = D + 1;
      end else begin
        povf = 0;
        pneg = ma < mb;
        pres = pneg ? (mb - ma) : (ma - mb);
        bl = pneg ? (2 * D + 1) : (D + 1);
      end
      eb = 1;
    end else begin
      bit amod;
      amod = 0;
      if (mc_in) begin mm = 0; mmv = 0; end
      else if (ms_in) begin mm = ma; mmv = 1; end
      else if (mr_in && mmv) begin ma = mm; amod = 1; end
      else if (clear_A) begin ma = 0; amod = 1; end
      else if (bksp_A) begin ma = ma / 10; amod = 1; end
      else if (load_A && digit <= 9) begin ma = (ma * 10 + int'(digit)) % P; amod = 1; end
      if (amod) begin movf = 0; mneg = 0; end
      if (clear_B) mb = 0;
      else if (bksp_B) mb = mb / 10;
      else if (load_B && digit <= 9) mb = (mb * 10 + int'(digit)) % P;
    end
    e.cyc = cyc; e.a = to_bcd(ma); e.b = to_bcd(mb); e.ovf = movf; e.neg = mneg;
    e.mv = mmv; e.busy = eb; e.done = ed; e.chk_a = (bl == 0); e.nm = nm;
    q.push_back(e);
    load_A = 0; load_B = 0; bksp_A = 0; bksp_B = 0; clear_A = 0; clear_B = 0;
    ex_start = 0; ms_in = 0; mr_in = 0; mc_in = 0;
  endtask

  // Monitor: compare the queued expectation for the edge just taken
  always @(negedge clock) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      bit bad;
      e = q.pop_front();
      checks++;
      bad = (bcd_B !== e.b) || (mem_valid !== e.mv) || (busy !== e.busy) || (done !== e.done);
      if (e.chk_a)
        bad = bad || (bcd_A !== e.a) || (overflow !== e.ovf) || (negative !== e.neg);
      if (bad) begin
        errors++;
        $display("FAIL %s cyc=%0d got A=%h B=%h ovf=%b neg=%b mv=%b busy=%b done=%b want A=%h B=%h ovf=%b neg=%b mv=%b busy=%b done=%b chkA=%0d",
                 e.nm, cyc, bcd_A, bcd_B, overflow, negative, mem_valid, busy, done,
                 e.a, e.b, e.ovf, e.neg, e.mv, e.busy, e.done, e.chk_a);
      end
    end
  end

  task automatic ldA(input logic [3:0] d); digit = d; load_A = 1; tick("loadA"); endtask
  task automatic ldB(input logic [3:0] d); digit = d; load_B = 1; tick("loadB"); endtask
  task automatic setA(input int v);
    clear_A = 1; tick("clrA");
    ldA(4'(v / 100)); ldA(4'((v / 10) % 10)); ldA(4'(v % 10));
  endtask
  task automatic setB(input int v);
    clear_B = 1; tick("clrB");
    ldB(4'(v / 100)); ldB(4'((v / 10) % 10)); ldB(4'(v % 10));
  endtask
  task automatic ex(input logic [1:0] op, input int waitn);
    op_code = op; ex_start = 1; tick("ex");
    repeat (waitn) tick("run");
  endtask

  initial begin
    // Reset state
    reset = 1; tick("reset"); tick("reset");
    reset = 0; tick("idle");

    // Entry
    ldA(1); ldA(2); ldA(3); ldA(4);
    bksp_A = 1; tick("bkspA");
    ldA(4'hA);
    clear_A = 1; tick("clrA");
    ldA(7);
    clear_A = 1; digit = 5; load_A = 1; tick("clr+load");

    // Add with overflow, then subtracts without and with borrow
    setA(234); setB(789); ex(2'b00, 5);
    setA(500); setB(123); ex(2'b01, 5);
    setA(123); setB(500); ex(2'b01, 8);

    // Boundaries
    setA(0);   setB(0);   ex(2'b01, 5);
    setA(456); setB(456); ex(2'b01, 5);
    setA(999); setB(999); ex(2'b00, 5);
    setA(1);   setB(999); ex(2'b01, 8);

    // Memory
    setA(42);
    ms_in = 1; tick("ms");
    clear_A = 1; tick("clrA");
    mr_in = 1; tick("mr");
    mc_in = 1; tick("mc");
    clear_A = 1; tick("clrA");
    mr_in = 1; tick("mr-empty");
    setA(17);
    ms_in = 1; tick("ms");
    mc_in = 1; ms_in = 1; tick("mc+ms");

    // Lockout while busy, then reserved op codes
    setA(321); setB(111);
    op_code = 0; ex_start = 1; tick("ex");
    digit = 9; load_A = 1; ms_in = 1; load_B = 1; tick("lock");
    clear_A = 1; clear_B = 1; tick("lock");
    op_code = 1; ex_start = 1; tick("lock-ex");
    repeat (3) tick("run");
    op_code = 2; ex_start = 1; tick("rsv");
    op_code = 3; ex_start = 1; digit = 6; load_A = 1; tick("rsv+load");
    tick("idle");

    // Reset two edges after ex_start, then a normal operation
    setA(250); setB(375);
    op_code = 0; ex_start = 1; tick("ex");
    tick("run");
    reset = 1; tick("reset-mid");
    reset = 0; repeat (2) tick("post-reset");
    setA(250); setB(375); ex(2'b00, 5);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int sel;
      reset    = ($urandom % 100 == 0);
      ex_start = ($urandom % 8 == 0);
      op_code  = 2'($urandom % 4);
      digit    = ($urandom % 4 == 0) ? 4'($urandom % 16) : 4'($urandom % 10);
      sel      = $urandom % 9;
      mc_in    = (sel == 1);
      ms_in    = (sel == 2);
      mr_in    = (sel == 3);
      clear_A  = (sel == 4);
      bksp_A   = (sel == 5);
      load_A   = (sel >= 6);
      load_B   = ($urandom % 2 == 0);
      bksp_B   = ($urandom % 5 == 0);
      clear_B  = ($urandom % 8 == 0);
      tick("rand");
      reset = 0;
    end
    repeat (10) tick("drain");

    @(negedge clock);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard-drain got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
